// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU op codes, FSM state
// encoding and datapath width.
package alu_share_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_TCP = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_LHI = 4'b1000;
  localparam logic [3:0] OP_WWD = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester named by rr_ptr. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic       any_valid,
  output logic       gnt_id
);

  always_comb begin
    any_valid = |req_valid;
    gnt_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external ALU between the EX stage (id 0) and the branch unit
// (id 1); owns the WWD output port and the sticky halted state.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WORD_SIZE  = alu_share_ctrl_pkg::WORD_SIZE,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op0,
  input  logic [3:0]           req_op1,
  input  logic [WORD_SIZE-1:0] req_a0,
  input  logic [WORD_SIZE-1:0] req_a1,
  input  logic [WORD_SIZE-1:0] req_b0,
  input  logic [WORD_SIZE-1:0] req_b1,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_ctrl,
  input  logic [WORD_SIZE-1:0] alu_c,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_data,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] output_port,
  output logic                 is_halted
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  logic [1:0] state;
  logic       rr_ptr;
  logic       cur_id;
  logic [3:0] settle_cnt;
  logic       any_valid;
  logic       gnt_id;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any_valid (any_valid),
    .gnt_id    (gnt_id)
  );

  // The accept strobe is only offered while idle, so a grant and the operand
  // capture always happen on the same edge.
  always_comb begin
    req_ready = 2'b00;
    if (state == ST_IDLE && any_valid) begin
      req_ready = id_onehot(gnt_id);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      cur_id      <= 1'b0;
      settle_cnt  <= 4'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= OP_ADD;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      output_port <= '0;
      is_halted   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            alu_a      <= gnt_id ? req_a1 : req_a0;
            alu_b      <= gnt_id ? req_b1 : req_b0;
            alu_ctrl   <= gnt_id ? req_op1 : req_op0;
            cur_id     <= gnt_id;
            rr_ptr     <= ~gnt_id;
            settle_cnt <= 4'd0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ALU inputs have been stable for SETTLE_CYC cycles once the counter
          // reaches its last value; alu_c is trusted only then.
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            state      <= ST_RESP;
            case (alu_ctrl)
              OP_WWD: begin
                output_port <= alu_a;
                rsp_data    <= alu_a;
              end
              OP_HLT: begin
                is_halted <= 1'b1;
                rsp_data  <= '0;
              end
              default: rsp_data <= alu_c;
            endcase
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= is_halted ? ST_HALT : ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
